// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register addresses,
// CON bit positions, FSM state types and the CON read-word packer.
package uart_pkg;

    localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
    localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
    localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

    localparam int CON_TX_IE    = 0;
    localparam int CON_RX_IE    = 1;
    localparam int CON_TX_DONE  = 2;
    localparam int CON_RX_READY = 3;
    localparam int CON_TX_BUSY  = 4;
    localparam int CON_RX_OVR   = 5;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Assemble the CON read value; undefined bits read as zero.
    function automatic logic [31:0] con_word(input logic [1:0] ie,
                                             input logic tx_done,
                                             input logic rx_ready,
                                             input logic tx_busy,
                                             input logic rx_ovr);
        logic [31:0] w;
        w = '0;
        w[CON_TX_IE]    = ie[0];
        w[CON_RX_IE]    = ie[1];
        w[CON_TX_DONE]  = tx_done;
        w[CON_RX_READY] = rx_ready;
        w[CON_TX_BUSY]  = tx_busy;
        w[CON_RX_OVR]   = rx_ovr;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: two-flop synchronizer, mid-bit sampling FSM, and a
// one-cycle valid / frame_err pulse at the stop-bit sample.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    rx_state_t     state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_reg;
    logic [7:0]    shift_reg;
    logic          valid_reg;
    logic          frame_err_reg;

    // Bring the asynchronous line into the clock domain; idle level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= rx;
            sync2_reg <= sync1_reg;
        end
    end

    // Receive FSM: qualify the start bit at half a bit, then sample each
    // data bit and the stop bit one full bit period apart (mid-bit).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RX_IDLE;
            cnt_reg       <= '0;
            bit_reg       <= '0;
            shift_reg     <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                RX_IDLE: begin
                    if (!sync2_reg) begin
                        state_reg <= RX_START;
                        cnt_reg   <= '0;
                        bit_reg   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_reg == HALF_M1) begin
                        cnt_reg   <= '0;
                        state_reg <= sync2_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_reg == FULL_M1) begin
                        cnt_reg   <= '0;
                        shift_reg <= {sync2_reg, shift_reg[7:1]};
                        if (bit_reg == 3'd7) begin
                            state_reg <= RX_STOP;
                        end else begin
                            bit_reg <= bit_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_reg == FULL_M1) begin
                        cnt_reg   <= '0;
                        state_reg <= RX_IDLE;
                        if (sync2_reg) begin
                            valid_reg <= 1'b1;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: state_reg <= RX_IDLE;
            endcase
        end
    end

    assign data      = shift_reg;
    assign valid     = valid_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: rtl/uart_periph.sv
// Memory-mapped UART peripheral: address decode, CON/RXD registers,
// 8N1 transmit FSM and the receive sub-block.
module uart_periph
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

    tx_state_t     tx_state_reg;
    logic [CW-1:0] tx_cnt_reg;
    logic [2:0]    tx_bit_reg;
    logic [7:0]    tx_shift_reg;
    logic          tx_reg;

    logic [1:0]    ie_reg;
    logic          tx_done_reg;
    logic          rx_ready_reg;
    logic          rx_ovr_reg;
    logic [7:0]    rxd_reg;

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_frame_err;

    logic sel_txd, sel_rxd, sel_con;
    logic txd_wr, con_wr, con_rd;
    logic tx_busy, tx_finish, rx_accept;
    logic unused_wdata;

    assign sel_txd = (addr == UART_TXD_ADDR);
    assign sel_rxd = (addr == UART_RXD_ADDR);
    assign sel_con = (addr == UART_CON_ADDR);
    assign txd_wr  = MemWrite & sel_txd;
    assign con_wr  = MemWrite & sel_con;
    assign con_rd  = MemRead & sel_con;

    assign tx_busy   = (tx_state_reg != TX_IDLE);
    assign tx_finish = (tx_state_reg == TX_STOP) && (tx_cnt_reg == FULL_M1);
    assign rx_accept = rx_valid & ~rx_frame_err;

    assign unused_wdata = ^wdata[31:8];

    uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (rx_byte),
        .valid     (rx_valid),
        .frame_err (rx_frame_err)
    );

    // Transmit FSM: each state holds BAUD_DIV cycles per bit; writes that
    // arrive while a frame is in flight are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_reg       <= 1'b1;
        end else begin
            case (tx_state_reg)
                TX_IDLE: begin
                    if (txd_wr) begin
                        tx_shift_reg <= wdata[7:0];
                        tx_state_reg <= TX_START;
                        tx_cnt_reg   <= '0;
                        tx_reg       <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt_reg == FULL_M1) begin
                        tx_cnt_reg   <= '0;
                        tx_bit_reg   <= '0;
                        tx_state_reg <= TX_DATA;
                        tx_reg       <= tx_shift_reg[0];
                        tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_reg == FULL_M1) begin
                        tx_cnt_reg <= '0;
                        if (tx_bit_reg == 3'd7) begin
                            tx_state_reg <= TX_STOP;
                            tx_reg       <= 1'b1;
                        end else begin
                            tx_bit_reg   <= tx_bit_reg + 3'd1;
                            tx_reg       <= tx_shift_reg[0];
                            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_reg == FULL_M1) begin
                        tx_cnt_reg   <= '0;
                        tx_state_reg <= TX_IDLE;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + CW'(1);
                    end
                end
                default: tx_state_reg <= TX_IDLE;
            endcase
        end
    end

    // CON/RXD state: a flag set in the same cycle as a clearing CON read wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_reg       <= '0;
            tx_done_reg  <= 1'b0;
            rx_ready_reg <= 1'b0;
            rx_ovr_reg   <= 1'b0;
            rxd_reg      <= '0;
        end else begin
            if (con_wr) begin
                ie_reg <= wdata[1:0];
            end
            tx_done_reg  <= tx_finish | (tx_done_reg & ~con_rd);
            rx_ready_reg <= rx_accept | (rx_ready_reg & ~con_rd);
            rx_ovr_reg   <= (rx_accept & rx_ready_reg) | (rx_ovr_reg & ~con_rd);
            if (rx_accept) begin
                rxd_reg <= rx_byte;
            end
        end
    end

    // Combinational read mux so the MEM/WB register can capture it this cycle.
    always_comb begin
        rdata = '0;
        if (MemRead) begin
            if (sel_rxd) begin
                rdata = {24'b0, rxd_reg};
            end else if (sel_con) begin
                rdata = con_word(ie_reg, tx_done_reg, rx_ready_reg, tx_busy, rx_ovr_reg);
            end
        end
    end

    assign tx  = tx_reg;
    assign irq = (ie_reg[0] & tx_done_reg) | (ie_reg[1] & rx_ready_reg);

endmodule

// File: tb/tb_uart_periph.sv
// Bench for uart_periph with BAUD_DIV = 16: register-access vector table,
// TX frame scoreboard fed by TXD writes, and hand sequences for RX corners.
module tb_uart_periph;

    localparam int B = 16;
    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rx;
    logic        tx;
    logic        irq;

    int tests = 0;
    int fails = 0;
    logic mon_en = 1'b0;
    logic [7:0] tx_exp_q[$];

    uart_periph #(.BAUD_DIV(B)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .wdata    (wdata),
        .rdata    (rdata),
        .rx       (rx),
        .tx       (tx),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", name, got);
        end
    endtask

    // Bus tasks start and end on a falling edge; the side effect happens on
    // the rising edge in between.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; MemWrite = 1'b1;
        @(posedge clk);
        @(negedge clk);
        MemWrite = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; MemRead = 1'b1;
        #1 d = rdata;
        @(posedge clk);
        @(negedge clk);
        MemRead = 1'b0; addr = '0;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (B) @(negedge clk);
        end
        rx = stop_bit;
        repeat (B) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_irq(input string name, input int max_cycles);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, irq}, 32'h1);
    endtask

    // TX scoreboard: decode each frame on tx at mid-bit and compare with
    // the byte queued when the accepted TXD write was issued.
    initial begin
        logic [7:0] got;
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                repeat (B / 2) @(negedge clk);
                check("tx_mon_start", {31'b0, tx}, 32'h0);
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    got[i] = tx;
                end
                repeat (B) @(negedge clk);
                check("tx_mon_stop", {31'b0, tx}, 32'h1);
                if (tx_exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL tx_mon_unexpected: got 0x%02h, expected no frame", got);
                end else begin
                    exp = tx_exp_q.pop_front();
                    check("tx_mon_byte", {24'b0, got}, {24'b0, exp});
                end
            end
        end
    end

    typedef struct {
        int          kind;   // 0 write, 1 read, 2 bus idle (MemRead low)
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] d;
        logic [9:0]  fr;
        int          bad;
        int          cnt;

        rst = 1'b1; addr = '0; MemRead = 1'b0; MemWrite = 1'b0; wdata = '0; rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_tx", {31'b0, tx}, 32'h1);
        check("reset_irq", {31'b0, irq}, 32'h0);

        // Register map vectors
        vecs[0]  = '{0, A_CON, 32'h0000_0003, 32'h0};
        vecs[1]  = '{1, A_CON, 32'h0,         32'h0000_0003};
        vecs[2]  = '{2, A_CON, 32'h0,         32'h0};
        vecs[3]  = '{0, A_CON, 32'hFFFF_FFFE, 32'h0};
        vecs[4]  = '{1, A_CON, 32'h0,         32'h0000_0002};
        vecs[5]  = '{1, A_TXD, 32'h0,         32'h0};
        vecs[6]  = '{1, A_RXD, 32'h0,         32'h0};
        vecs[7]  = '{1, 32'h4000_0024, 32'h0, 32'h0};
        vecs[8]  = '{1, 32'h4000_0021, 32'h0, 32'h0};
        vecs[9]  = '{0, A_RXD, 32'h0000_00AB, 32'h0};
        vecs[10] = '{1, A_RXD, 32'h0,         32'h0};
        vecs[11] = '{0, A_CON, 32'h0,         32'h0};
        for (int i = 0; i < 12; i++) begin
            case (vecs[i].kind)
                0: bus_write(vecs[i].a, vecs[i].d);
                1: begin
                    bus_read(vecs[i].a, d);
                    check($sformatf("vec%0d_read_%08h", i, vecs[i].a), d, vecs[i].exp);
                end
                default: begin
                    addr = vecs[i].a;
                    #1 check($sformatf("vec%0d_idle_rdata", i), rdata, vecs[i].exp);
                    @(negedge clk);
                    addr = '0;
                end
            endcase
        end
        read_check("con_after_table", A_CON, 32'h0);

        // TX 0xA5 with tx irq enabled: exact waveform and done timing
        mon_en = 1'b1;
        bus_write(A_CON, 32'h1);
        tx_exp_q.push_back(8'hA5);
        bus_write(A_TXD, 32'h0000_00A5);
        fr = {1'b1, 8'hA5, 1'b0};
        bad = 0;
        for (int c = 0; c < 10 * B; c++) begin
            if (tx !== fr[c / B]) bad++;
            if (c == 10 * B - 1) check("tx_irq_before_done", {31'b0, irq}, 32'h0);
            @(negedge clk);
        end
        check("tx_wave_mismatch_cycles", bad, 0);
        check("tx_irq_at_160", {31'b0, irq}, 32'h1);
        read_check("tx_con_done", A_CON, 32'h05);
        check("tx_irq_cleared", {31'b0, irq}, 32'h0);
        read_check("tx_con_after_clear", A_CON, 32'h01);

        // Write while busy is dropped
        tx_exp_q.push_back(8'h11);
        bus_write(A_TXD, 32'h11);
        repeat (4) @(negedge clk);
        bus_write(A_TXD, 32'h22);
        read_check("busy_con", A_CON, 32'h11);
        wait_irq("busy_frame_done", 400);
        read_check("busy_con_done", A_CON, 32'h05);
        cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) cnt++;
        end
        check("busy_no_second_frame", cnt, 0);

        // Write on the stop-end edge is dropped; write on the first idle cycle
        // starts immediately after the stop bit
        tx_exp_q.push_back(8'h5A);
        bus_write(A_TXD, 32'h5A);
        repeat (10 * B - 1) @(negedge clk);
        bus_write(A_TXD, 32'h77);
        tx_exp_q.push_back(8'hC3);
        bus_write(A_TXD, 32'hC3);
        check("b2b_start_no_gap", {31'b0, tx}, 32'h0);
        repeat (10 * B + 10) @(negedge clk);
        read_check("b2b_con_done", A_CON, 32'h05);

        // RX 0x3C with rx irq enabled
        bus_write(A_CON, 32'h2);
        send_frame(8'h3C, 1'b1);
        wait_irq("rx_irq", 40);
        read_check("rx_rxd", A_RXD, 32'h3C);
        read_check("rx_con_first", A_CON, 32'h0A);
        read_check("rx_con_second", A_CON, 32'h02);

        // Overrun: two frames without reading CON
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        repeat (10) @(negedge clk);
        read_check("ovr_rxd", A_RXD, 32'h02);
        read_check("ovr_con", A_CON, 32'h2A);
        read_check("ovr_con_cleared", A_CON, 32'h02);

        // Framing error: stop bit low
        send_frame(8'h55, 1'b0);
        repeat (40) @(negedge clk);
        check("frame_err_irq", {31'b0, irq}, 32'h0);
        read_check("frame_err_rxd", A_RXD, 32'h02);
        read_check("frame_err_con", A_CON, 32'h02);

        // Short low glitch is a false start
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        read_check("glitch_con", A_CON, 32'h02);
        read_check("glitch_rxd", A_RXD, 32'h02);

        // CON read on the very edge rx_ready sets: pre-edge value, flag kept
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (155) @(negedge clk);
                read_check("race_con_pre_edge", A_CON, 32'h02);
            end
        join
        check("race_flag_kept_irq", {31'b0, irq}, 32'h1);
        read_check("race_rxd", A_RXD, 32'h99);

        // Reset in the middle of a TX frame
        mon_en = 1'b0;
        bus_write(A_CON, 32'h3);
        bus_write(A_TXD, 32'h00);
        repeat (40) @(negedge clk);
        check("pre_reset_tx_low", {31'b0, tx}, 32'h0);
        check("pre_reset_irq", {31'b0, irq}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_tx_high", {31'b0, tx}, 32'h1);
        rst = 1'b0;
        check("reset_mid_irq", {31'b0, irq}, 32'h0);
        read_check("reset_mid_con", A_CON, 32'h0);
        read_check("reset_mid_rxd", A_RXD, 32'h0);
        cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) cnt++;
        end
        check("reset_no_resume", cnt, 0);

        check("tx_queue_empty", tx_exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_periph.md
# uart_periph

Memory-mapped UART peripheral on the CPU data-memory bus, sitting directly downstream of the MEM stage. It converts CPU stores into 8N1 serial frames on `tx` and assembles frames from `rx` into a readable byte. Status flags and an interrupt line feed the CPU's `irq` input. Reads are combinational so that `rdata` can be latched by the MEM/WB register in the same cycle.

## Interface
Parameters:
- `BAUD_DIV`, default 5208: clock cycles per bit (50 MHz / 9600). Must be ≥ 4.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `addr` in 32: byte address from the EX/MEM ALU result. Only the full addresses below are decoded.
- `MemRead` in 1: read strobe. Read side effects take effect at the clock edge.
- `MemWrite` in 1: write strobe.
- `wdata` in 32: store data. Only bits [7:0] are used, plus [1:0] for CON.
- `rdata` out 32: combinational read data. It is 0 for unmapped addresses or when `MemRead` = 0.
- `rx` in 1: asynchronous serial input, idle high.
- `tx` out 1: serial output, idle high.
- `irq` out 1: level interrupt.

## Operation
- Register map:
  - `0x4000_0018` TXD: write-only; a write starts a transmit. Reads return 0.
  - `0x4000_001C` RXD: read-only; [7:0] holds the last received byte.
  - `0x4000_0020` CON: bits as listed below.
- CON bits:
  - [0] tx irq enable (R/W).
  - [1] rx irq enable (R/W).
  - [2] tx_done (RO, clear-on-read).
  - [3] rx_ready (RO, clear-on-read).
  - [4] tx_busy (RO).
  - [5] rx_overrun (RO, clear-on-read).
  - All other bits read 0.
- CON writes affect only [1:0].
- `irq = (CON[0] & tx_done) | (CON[1] & rx_ready)`.
- TX FSM, states TX_IDLE → TX_START → TX_DATA(8 bits, LSB first) → TX_STOP → TX_IDLE. Each state holds for exactly `BAUD_DIV` cycles per bit.
- A TXD write in TX_IDLE latches `wdata[7:0]` and enters TX_START.
- A TXD write while tx_busy is silently dropped: no state change, no flag.
- At the end of TX_STOP, set tx_done and return to TX_IDLE.
- RX input path: `rx` passes through a 2-flop synchronizer. RX FSM states are RX_IDLE, RX_START, RX_DATA, RX_STOP.
- RX_IDLE: a synchronized low enters RX_START with the bit counter cleared.
- RX_START: sample at `BAUD_DIV/2`.
  - If high, it is a false start; return to RX_IDLE.
  - If low, go to RX_DATA.
- RX_DATA: sample each bit every `BAUD_DIV` cycles (mid-bit), shifting in LSB first.
- RX_STOP: sample the stop bit at mid-bit.
  - If 1, write the byte to RXD and set rx_ready. If rx_ready was already set, also set rx_overrun; RXD is overwritten.
  - If 0 (framing error), discard the byte and leave the flags unchanged.
  - Either way, return to RX_IDLE immediately after the stop sample.
- Simultaneous events:
  - A CON read in the same cycle that a flag is set: the set wins, so the flag stays 1. `rdata` shows the pre-edge value.
  - A RXD read does not clear rx_ready; only a CON read clears flags.
  - A TXD write on the same cycle as the TX_STOP end is dropped, because busy is still 1 in that cycle.
- Reset, and reset mid-frame: both FSMs go to IDLE, counters clear, and `tx` = 1 in the next cycle. All CON bits, RXD and the TX shift register are set to 0, so `irq` = 0.

## Timing
- TXD write sampled at edge k: `tx` falls at k+1. The frame lasts `10*BAUD_DIV` cycles.
- tx_busy is 1 from k+1 through the last stop-bit cycle.
- tx_done sets at edge k + `10*BAUD_DIV`, and tx_busy clears on the same edge.
- RX: `rx` fall at edge j is seen by the FSM at j+2.
- rx_ready sets about `9.5*BAUD_DIV` + 2 cycles after the start edge.
- `rdata` and `irq` have zero-cycle combinational delay from register state. `irq` follows flag changes one edge after the event.
- A back-to-back TXD write issued on the first idle cycle starts the next frame with no gap beyond the stop bit.

## Structure
- Shared package `uart_pkg` holds:
  - address constants `UART_TXD_ADDR`, `UART_RXD_ADDR`, `UART_CON_ADDR`;
  - CON bit indices;
  - enums `tx_state_t` and `rx_state_t`.
- One natural sub-module: `uart_rx`, containing the synchronizer, RX FSM and bit counters. It outputs `byte[7:0]`, `valid` (1-cycle pulse) and `frame_err`.
- TX FSM, register file and decode live in `uart_periph`.

## Test plan
All scenarios use `BAUD_DIV` = 16.
- Reset check: assert `rst` mid-TX frame → next cycle `tx` = 1, CON reads 0x00, `irq` = 0.
- TX: write 0xA5 to TXD with CON = 0x01.
  - Required: `tx` carries 0,1,0,1,0,0,1,0,1,1, each level held 16 cycles.
  - tx_done and `irq` = 1 at cycle 160 after the write.
  - A CON read then returns 0x05 and clears `irq`.
- TX busy drop: write 0x11, then 0x22 at +5 cycles → only 0x11 is transmitted; CON[4] = 1 during the frame.
- RX: drive the 0x3C frame on `rx` with CON = 0x02 → rx_ready and `irq` = 1; RXD reads 0x3C. A CON read returns 0x0A then 0x02.
- RX overrun and framing:
  - Send 0x01 then 0x02 without reading → RXD = 0x02, CON[5] = 1.
  - A frame with stop bit 0 → RXD unchanged, no flag.
  - A 4-cycle low glitch → no reception.
- Set-vs-clear race: a CON read on the exact edge rx_ready sets → flag remains 1 afterward.
